// File: rtl/ascon_pkg.sv
// +-----------------------------------------------------------------------------+
// | ascon_pkg : shared constants and FSM state type for the Ascon-Hash control   |
// | Revision  : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

package ascon_pkg;

  localparam logic [63:0]  ASCON_IV             = 64'h00400c0000000100;
  localparam int           ASCON_DEFAULT_ROUNDS = 12;

  // State after P12 of (IV || 0^256); lets the INIT permutation be skipped.
  localparam logic [319:0] ASCON_IV_PRECOMP = {
    64'hee9398aadb67f03d, 64'h8bb21831c60f1002, 64'hb48a92db98d5da62,
    64'h43189921b8f8e3e8, 64'h348fa5c9d525e140
  };

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_ABSORB    = 3'd2,
    ST_PERM_GO   = 3'd3,
    ST_PERM_WAIT = 3'd4,
    ST_SQUEEZE   = 3'd5
  } ascon_state_t;

endpackage

`default_nettype wire

// File: rtl/ascon_pad.sv
// +-----------------------------------------------------------------------------+
// | ascon_pad : keeps the first nbytes bytes of a word and appends the 0x80 pad  |
// | Revision  : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module ascon_pad (
  input  logic [63:0] data,
  input  logic [2:0]  nbytes,
  output logic [63:0] padded
);

  logic [5:0]  w_shift;
  logic [63:0] w_keep_mask;
  logic [63:0] w_pad_bit;

  // Byte 0 is the most significant byte, so kept bytes are the top ones.
  always_comb begin
    w_shift     = {nbytes, 3'b000};
    w_keep_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> w_shift);
    w_pad_bit   = 64'h80 << (6'd56 - w_shift);
    padded      = (data & w_keep_mask) ^ w_pad_bit;
  end

endmodule

`default_nettype wire

// File: rtl/ascon_hash_ctrl.sv
// +-----------------------------------------------------------------------------+
// | ascon_hash_ctrl : Ascon-Hash sponge controller driving an external          |
// |                   permutation core. Define ASCON_HASH_IV_PRECOMP_EN to start |
// |                   from the precomputed initial state.                        |
// | Revision        : 1.0                                                        |
// +-----------------------------------------------------------------------------+
`default_nettype none

module ascon_hash_ctrl
  import ascon_pkg::*;
#(
  parameter int PERM_ROUNDS = ASCON_DEFAULT_ROUNDS,
  parameter int HASH_WORDS  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [63:0]  msg_data,
  input  logic         msg_last,
  input  logic [2:0]   msg_bytes,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic [63:0]  hash_data,
  output logic         hash_last,
  output logic         busy,
  output logic [319:0] perm_S,
  output logic [4:0]   perm_round,
  output logic         perm_start,
  input  logic [319:0] perm_S_out,
  input  logic         perm_fin
);

  localparam int              CNT_W     = $clog2(HASH_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(HASH_WORDS - 1);

  ascon_state_t     state_q, state_d;
  ascon_state_t     ret_q, ret_d;
  logic [319:0]     s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             msg_ready_q, msg_ready_d;
  logic             hash_valid_q, hash_valid_d;
  logic             hash_last_q, hash_last_d;
  logic             perm_start_q, perm_start_d;
  logic             busy_q, busy_d;
  logic [63:0]      w_padded;

  ascon_pad u_pad (
    .data   (msg_data),
    .nbytes (msg_bytes),
    .padded (w_padded)
  );

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (msg_valid) begin
          cnt_d = '0;
`ifdef ASCON_HASH_IV_PRECOMP_EN
          s_d     = ASCON_IV_PRECOMP;
          state_d = ST_ABSORB;
`else
          s_d     = {ASCON_IV, 256'b0};
          ret_d   = ST_ABSORB;
          state_d = ST_PERM_GO;
`endif
        end
      end
      ST_ABSORB: begin
        if (msg_valid && msg_ready_q) begin
          s_d[319:256] = s_q[319:256] ^ (msg_last ? w_padded : msg_data);
          ret_d        = msg_last ? ST_SQUEEZE : ST_ABSORB;
          state_d      = ST_PERM_GO;
        end
      end
      ST_PERM_GO: state_d = ST_PERM_WAIT;
      ST_PERM_WAIT: begin
        if (perm_fin) begin
          s_d     = perm_S_out;
          state_d = ret_q;
        end
      end
      ST_SQUEEZE: begin
        if (hash_ready && hash_valid_q) begin
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            ret_d   = ST_SQUEEZE;
            state_d = ST_PERM_GO;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs decode the next state so they are flops, free of input paths.
    msg_ready_d  = (state_d == ST_ABSORB);
    hash_valid_d = (state_d == ST_SQUEEZE);
    hash_last_d  = (state_d == ST_SQUEEZE) && (cnt_d == LAST_WORD);
    perm_start_d = (state_d == ST_PERM_GO);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_ABSORB;
      s_q          <= '0;
      cnt_q        <= '0;
      msg_ready_q  <= 1'b0;
      hash_valid_q <= 1'b0;
      hash_last_q  <= 1'b0;
      perm_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      s_q          <= s_d;
      cnt_q        <= cnt_d;
      msg_ready_q  <= msg_ready_d;
      hash_valid_q <= hash_valid_d;
      hash_last_q  <= hash_last_d;
      perm_start_q <= perm_start_d;
      busy_q       <= busy_d;
    end
  end

  assign msg_ready  = msg_ready_q;
  assign hash_valid = hash_valid_q;
  assign hash_last  = hash_last_q;
  assign hash_data  = s_q[319:256];
  assign perm_start = perm_start_q;
  assign busy       = busy_q;
  assign perm_S     = s_q;
  assign perm_round = 5'(PERM_ROUNDS);

endmodule

`default_nettype wire
